// File: rtl/palindrome_datapath_if.sv
// Handshake bundle between the palindrome control FSM and its symbol datapath.
// The control side (master) issues strobes and symbols.
// The datapath side (slave) returns the status bits the FSM branches on.
interface palindrome_datapath_if #(
   parameter int SW = 2,
   parameter int AW = 4
);

   logic          load;
   logic          select;
   logic          in_valid;
   logic [SW-1:0] in_symbol;
   logic          a_ne_b;
   logic          front_ge_back;
   logic [AW:0]   length;
   logic          overflow;

   modport master (
      output load, select, in_valid, in_symbol,
      input  a_ne_b, front_ge_back, length, overflow
   );

   modport slave (
      input  load, select, in_valid, in_symbol,
      output a_ne_b, front_ge_back, length, overflow
   );

endinterface

// File: rtl/palindrome_datapath.sv
// Symbol buffer plus front/back comparison datapath for the palindrome FSM.
// The FSM fills the buffer while select is low.
// It then alternates Compare/Shift while select is high.
// Pointers walk inward in lock-step with that alternation.
module palindrome_datapath #(
   parameter int SW    = 2,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input logic                clock,
   input logic                reset,
   palindrome_datapath_if.slave bus
);

   typedef enum logic [1:0] {
      FILL = 2'd0,
      CMP  = 2'd1,
      SHF  = 2'd2,
      HOLD = 2'd3
   } StepState;

   localparam logic [AW:0] FullLength = (AW+1)'(DEPTH);
   localparam logic [AW:0] One        = (AW+1)'(1);
   localparam logic [AW:0] Two        = (AW+1)'(2);

   StepState      step;
   logic [AW:0]   length;
   logic [AW:0]   front;
   logic [AW:0]   back;
   logic          overflow;
   logic [SW-1:0] mem [DEPTH];

   logic          bufferFull;
   logic          fillActive;
   logic          writeEnable;
   logic [AW:0]   newLength;
   logic          aNeB;
   logic          frontGeBack;

   // Decide whether this cycle appends a symbol, and what the length becomes.
   // Symbols are only accepted in fill mode; anything offered while comparing is ignored.
   always_comb begin
      bufferFull  = (length == FullLength);
      fillActive  = bus.load && !bus.select && (step == FILL);
      writeEnable = fillActive && bus.in_valid && !bufferFull;
      newLength   = writeEnable ? (length + One) : length;
   end

   // Status bits are derived from registered state only, so the FSM sees them with zero latency.
   // front_ge_back looks one advance ahead: it tells Shift whether this step finishes the walk.
   always_comb begin
      aNeB        = 1'b0;
      frontGeBack = 1'b1;
      if (length != '0) begin
         aNeB = (mem[front[AW-1:0]] != mem[back[AW-1:0]]);
      end
      if (length > One) begin
         frontGeBack = ((front + Two) >= back);
      end
   end

   // Buffer storage has no reset; stale entries are never read past the current length.
   always_ff @(posedge clock) begin
      if (writeEnable) begin
         mem[length[AW-1:0]] <= bus.in_symbol;
      end
   end

   // Step sequencer and pointer/length registers.
   // load low empties the buffer and parks in FILL.
   // A low select always returns to FILL without clearing length, so the next round appends.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         step     <= FILL;
         length   <= '0;
         front    <= '0;
         back     <= '0;
         overflow <= 1'b0;
      end else if (!bus.load) begin
         step     <= FILL;
         length   <= '0;
         front    <= '0;
         overflow <= 1'b0;
      end else if (!bus.select) begin
         step <= FILL;
         if (step == FILL) begin
            length <= newLength;
            front  <= '0;
            back   <= newLength - One;
            if (bus.in_valid && bufferFull) begin
               overflow <= 1'b1;
            end
         end
      end else begin
         unique case (step)
            FILL: begin
               step <= CMP;
            end
            CMP: begin
               step <= aNeB ? HOLD : SHF;
            end
            SHF: begin
               front <= front + One;
               back  <= back - One;
               step  <= frontGeBack ? HOLD : CMP;
            end
            HOLD: begin
               step <= HOLD;
            end
            default: begin
               step <= FILL;
            end
         endcase
      end
   end

   assign bus.a_ne_b        = aNeB;
   assign bus.front_ge_back = frontGeBack;
   assign bus.length        = length;
   assign bus.overflow      = overflow;

endmodule

// File: tb/tb_palindrome_datapath.sv
// Directed bench for palindrome_datapath.
// A vector table covers fill/compare/hold/restart.
// Hand-written sequences cover overflow, load clearing and async reset.
module tb_palindrome_datapath;

   logic clock;
   logic reset;
   int   checks;
   int   errors;

   palindrome_datapath_if #(.SW(2), .AW(4)) bus ();

   palindrome_datapath #(.SW(2), .DEPTH(16), .AW(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic       load;
      logic       select;
      logic       inValid;
      logic [1:0] inSymbol;
      logic       expANeB;
      logic       expFgb;
      logic [4:0] expLength;
      logic       expOverflow;
      logic       chkPtr;
      logic [4:0] expFront;
      logic [4:0] expBack;
   } VectorT;

   VectorT vectors [20];

   // Free-running clock, period 10.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drive one cycle of inputs away from the edge, then settle just after the edge.
   task automatic applyStimulus(input logic ld, input logic sel, input logic v, input logic [1:0] sym);
      @(negedge clock);
      bus.load      = ld;
      bus.select    = sel;
      bus.in_valid  = v;
      bus.in_symbol = sym;
      @(posedge clock);
      #1;
   endtask

   // Compare the four datapath outputs against expected values.
   task automatic checkOutput(input string tag, input logic expA, input logic expF,
                              input logic [4:0] expLen, input logic expOv);
      checks++;
      if (bus.a_ne_b !== expA) begin
         errors++;
         $display("[TB] FAIL %s a_ne_b: got %0b expected %0b", tag, bus.a_ne_b, expA);
      end
      checks++;
      if (bus.front_ge_back !== expF) begin
         errors++;
         $display("[TB] FAIL %s front_ge_back: got %0b expected %0b", tag, bus.front_ge_back, expF);
      end
      checks++;
      if (bus.length !== expLen) begin
         errors++;
         $display("[TB] FAIL %s length: got %0d expected %0d", tag, bus.length, expLen);
      end
      checks++;
      if (bus.overflow !== expOv) begin
         errors++;
         $display("[TB] FAIL %s overflow: got %0b expected %0b", tag, bus.overflow, expOv);
      end
   endtask

   // Compare the internal front/back pointers against expected positions.
   task automatic checkPointers(input string tag, input logic [4:0] expF, input logic [4:0] expB);
      checks++;
      if (dut.front !== expF || dut.back !== expB) begin
         errors++;
         $display("[TB] FAIL %s pointers: got front=%0d back=%0d expected front=%0d back=%0d",
                  tag, dut.front, dut.back, expF, expB);
      end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      reset         = 1'b0;
      bus.load      = 1'b0;
      bus.select    = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_symbol = 2'd0;

      //            ld    sel   vld   sym    a     fgb   len    ov    chk   front  back
      vectors[0]  = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 5'd0, 5'd0};
      vectors[1]  = '{1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 5'd2, 1'b0, 1'b1, 5'd0, 5'd1};
      vectors[2]  = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 5'd0, 5'd2};
      vectors[3]  = '{1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 5'd0, 5'd2};
      vectors[4]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 5'd0, 5'd2};
      vectors[5]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 5'd1, 5'd1};
      vectors[6]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 5'd1, 5'd1};
      vectors[7]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0};
      vectors[8]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 5'd0, 5'd0};
      vectors[9]  = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 5'd2, 1'b0, 1'b1, 5'd0, 5'd1};
      vectors[10] = '{1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 5'd0, 5'd2};
      vectors[11] = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 5'd4, 1'b0, 1'b1, 5'd0, 5'd3};
      vectors[12] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 5'd4, 1'b0, 1'b1, 5'd0, 5'd3};
      vectors[13] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 5'd4, 1'b0, 1'b1, 5'd0, 5'd3};
      vectors[14] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 5'd1, 5'd2};
      vectors[15] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 5'd1, 5'd2};
      vectors[16] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 5'd1, 5'd2};
      vectors[17] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 5'd1, 5'd2};
      vectors[18] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 5'd4, 1'b0, 1'b1, 5'd0, 5'd3};
      vectors[19] = '{1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 5'd0, 5'd4};

      // Reset state with no stimulus.
      #1 reset = 1'b1;
      #2;
      checkOutput("reset", 1'b0, 1'b1, 5'd0, 1'b0);
      checkPointers("reset", 5'd0, 5'd0);
      @(negedge clock);
      reset = 1'b0;

      // Table: palindrome 1,2,1 then mismatch 0,1,2,0, then restart-and-append.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(vectors[i].load, vectors[i].select, vectors[i].inValid, vectors[i].inSymbol);
         checkOutput($sformatf("vec%0d", i), vectors[i].expANeB, vectors[i].expFgb,
                     vectors[i].expLength, vectors[i].expOverflow);
         if (vectors[i].chkPtr) begin
            checkPointers($sformatf("vec%0d", i), vectors[i].expFront, vectors[i].expBack);
         end
      end

      // Overfill with seventeen 3s: length saturates at 16, overflow appears on the 17th.
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
      for (int i = 1; i <= 17; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 2'd3);
         checkOutput($sformatf("fill%0d", i), 1'b0, (i <= 3) ? 1'b1 : 1'b0,
                     (i > 16) ? 5'd16 : 5'(i), (i > 16) ? 1'b1 : 1'b0);
      end

      // Compare all-equal buffer: eight Compare/Shift pairs, front_ge_back only on the last pair.
      for (int k = 0; k < 16; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
         checkOutput($sformatf("walk%0d", k), 1'b0, (k >= 14) ? 1'b1 : 1'b0, 5'd16, 1'b1);
         checkPointers($sformatf("walk%0d", k), 5'(k / 2), 5'(15 - k / 2));
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
      checkOutput("walkHold", 1'b0, 1'b1, 5'd16, 1'b1);
      checkPointers("walkHold", 5'd8, 5'd7);

      // Back to fill while full: extra symbols are dropped and overflow stays sticky.
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, 2'd2);
      applyStimulus(1'b1, 1'b0, 1'b1, 2'd2);
      checkOutput("fullAppend", 1'b0, 1'b0, 5'd16, 1'b1);

      // One-cycle load=0 clears length and overflow; compare of empty buffer reports done.
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
      checkOutput("loadClear", 1'b0, 1'b1, 5'd0, 1'b0);
      checkPointers("loadClear", 5'd0, dut.back);
      applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
      checkOutput("emptyCmp", 1'b0, 1'b1, 5'd0, 1'b0);

      // Asynchronous reset in the middle of a Shift cycle.
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, 2'd2);
      applyStimulus(1'b1, 1'b0, 1'b1, 2'd1);
      applyStimulus(1'b1, 1'b0, 1'b1, 2'd1);
      applyStimulus(1'b1, 1'b0, 1'b1, 2'd2);
      checkOutput("preFill", 1'b0, 1'b0, 5'd4, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
      checkOutput("preCmp", 1'b0, 1'b0, 5'd4, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
      checkOutput("preShf", 1'b0, 1'b0, 5'd4, 1'b0);
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      checkOutput("asyncReset", 1'b0, 1'b1, 5'd0, 1'b0);
      checkPointers("asyncReset", 5'd0, 5'd0);
      @(negedge clock);
      reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
      checkOutput("postReset", 1'b0, 1'b1, 5'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/palindrome_datapath.md
Name: palindrome_datapath

Overview:
- Symbol buffer and comparison datapath that sits directly under the palindrome/sequence control FSM.
- Consumes the FSM's `load` and `select` strobes. Captures a symbol stream into an internal buffer while the FSM is idle or starting.
- Walks front/back pointers inward during comparison, in lock-step with the FSM's Compare/Shift alternation.
- Produces the `a_ne_b` and `front_ge_back` status bits the FSM branches on.

Parameters:
- SW, 2, symbol width in bits (4 Simon colours).
- DEPTH, 16, maximum stored symbols.
- AW, 4, pointer width; DEPTH = 2**AW.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  from control; 0 = clear/hold-empty, 1 = datapath active.
- select  input  1  from control; 0 = fill mode, 1 = compare mode.
- in_valid  input  1  in_symbol valid this cycle (fill mode only).
- in_symbol  input  SW  symbol to append.
- a_ne_b  output  1  mem[front] != mem[back].
- front_ge_back  output  1  pointers meet or cross after the next advance.
- length  output  AW+1  number of stored symbols, 0..DEPTH.
- overflow  output  1  sticky; a write was dropped because the buffer was full.

Behaviour:
- Reset (async, immediate):
  - length=0, front=0, back=0, step=FILL, overflow=0.
  - Outputs: a_ne_b=0, front_ge_back=1, length=0, overflow=0.
  - Buffer contents need no reset.
- load=0 (synchronous, overrides everything):
  - length<=0, front<=0, overflow<=0, step<=FILL.
  - No writes.
- Internal step FSM, 4 states: FILL, CMP, SHF, HOLD.
- FILL, select=0:
  - in_valid=1 and length<DEPTH: write mem[length]<=in_symbol, length<=length+1.
  - in_valid=1 and length==DEPTH: drop the symbol, overflow<=1.
  - front<=0. back<=(new length)-1, computed in AW+1 bits; meaningless when length==0.
- Any state with select=0: step<=FILL. This restarts fill without clearing length, so a new go appends.
- FILL, select=1: step<=CMP.
  - This first cycle aligns with the control's last Start cycle, so CMP coincides with the control's Compare state.
  - No write, even if in_valid=1.
- CMP:
  - a_ne_b=1: step<=HOLD.
  - Otherwise step<=SHF.
  - Pointers unchanged.
- SHF:
  - front<=front+1, back<=back-1.
  - front_ge_back=1: step<=HOLD.
  - Otherwise step<=CMP.
- HOLD: pointers frozen until select=0.
- Outputs are combinational from registered state (zero latency; valid in the cycle the FSM samples them):
  - a_ne_b = (mem[front] != mem[back]) when length>=1; forced 0 when length==0.
  - front_ge_back = (front+2 >= back), compared in AW+1 bits unsigned. This is the post-advance test, so it is valid during SHF for that cycle's transition.
  - front_ge_back is forced 1 when length<=1.
  - Both outputs are meaningful in any step state; the FSM only samples them in Compare/Shift.
- Simultaneous in_valid with select=1: write ignored.
- Full buffer: length saturates at DEPTH; overflow stays set until reset or load=0.
- Pointer arithmetic never wraps in normal operation, because back>=front holds whenever step is CMP or SHF.
- Reset mid-compare: immediate return to the reset state; outputs as above.

Test Plan:
- Reset with no stimulus -> a_ne_b=0, front_ge_back=1, length=0, overflow=0.
- Fill 1,2,1 (select=0, in_valid 3 cycles), then select=1 -> length=3.
  - CMP: a_ne_b=0 (mem[0]=1, mem[2]=1).
  - SHF: front_ge_back=1 (0+2>=2).
  - Step state goes HOLD.
- Fill 0,1,2,0:
  - First CMP: a_ne_b=0.
  - First SHF: front_ge_back=0 (0+2<3).
  - Second CMP: front=1, back=2, a_ne_b=1 (1 vs 2); step state goes HOLD with pointers frozen.
- Fill 17 symbols of value 3 with DEPTH=16 -> length=16, overflow=1 on cycle 17; compare of all-equal symbols ends with front_ge_back=1 and no a_ne_b.
- Fill 2 symbols, pulse load=0 for one cycle -> length=0, overflow=0; then select=1 -> front_ge_back=1 immediately.
- Assert reset asynchronously mid-SHF (between clock edges) -> outputs reach reset values before the next clock edge; length=0.
